// File: rtl/pc_ras_pkg.sv
// Shared defaults and jump-mux encodings for the PLP program counter.
package pc_ras_pkg;
    localparam int          W_DATA_DEF       = 32;
    localparam int          W_JADDR_DEF      = 26;
    localparam int          RAS_DEPTH_DEF    = 4;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] IRQ_VECTOR_DEF   = 32'h0000_0004;

    // c_jjr selects the register-jump source
    localparam logic MUX_JADDR = 1'b0;
    localparam logic MUX_JRA   = 1'b1;
endpackage

// File: rtl/pc_ras_ras_stack.sv
// Circular return-address stack. push/pop arrive already qualified
// (no stall, no interrupt taken); push+pop together replaces the top.
module ras_stack #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full,
    output logic         uflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [PW-1:0]           tp;
    logic [PW-1:0]           tp_inc;
    logic [CW-1:0]           cnt;

    assign tp_inc = tp + 1'b1;
    assign empty  = (cnt == '0);
    assign full   = (cnt == CW'(DEPTH));
    // An empty stack returns 0 so a stray return lands on a known address
    assign top    = empty ? '0 : mem[tp];

    // Pointer, count, entries and the one-cycle underflow pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            mem   <= '0;
            tp    <= '0;
            cnt   <= '0;
            uflow <= 1'b0;
        end else begin
            uflow <= 1'b0;
            if (push && pop) begin
                mem[tp] <= wdata;
            end else if (push) begin
                // When full the oldest entry is overwritten and cnt saturates
                mem[tp_inc] <= wdata;
                tp          <= tp_inc;
                if (!full) cnt <= cnt + 1'b1;
            end else if (pop) begin
                if (empty) begin
                    uflow <= 1'b1;
                end else begin
                    tp  <= tp - 1'b1;
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/pc_ras.sv
// PLP program counter with return-address stack, branch condition input
// and a single-level interrupt return path.
module pc_ras
    import pc_ras_pkg::*;
#(
    parameter int                W_DATA       = W_DATA_DEF,
    parameter int                W_JADDR      = W_JADDR_DEF,
    parameter int                RAS_DEPTH    = RAS_DEPTH_DEF,
    parameter logic [W_DATA-1:0] RESET_VECTOR = W_DATA'(RESET_VECTOR_DEF),
    parameter logic [W_DATA-1:0] IRQ_VECTOR   = W_DATA'(IRQ_VECTOR_DEF)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic [W_DATA-3:0]  imm,
    input  logic [W_DATA-1:0]  jra,
    input  logic [W_JADDR-1:0] jaddr,
    input  logic               c_b,
    input  logic               br_cond,
    input  logic               c_j,
    input  logic               c_jjr,
    input  logic               c_call,
    input  logic               c_ret,
    input  logic               c_eret,
    input  logic               irq,
    output logic [W_DATA-1:0]  imem_addr,
    output logic [W_DATA-1:0]  jalra,
    output logic [W_DATA-1:0]  epc,
    output logic               ie,
    output logic               ras_empty,
    output logic               ras_full,
    output logic               ras_uflow
);
    logic [W_DATA-1:0] pc;
    logic [W_DATA-1:0] pc_4;
    logic [W_DATA-1:0] baddr;
    logic [W_DATA-1:0] jtarget;
    logic [W_DATA-1:0] ras_top;
    logic [W_DATA-1:0] next_pc;
    logic              irq_take;
    logic              ras_upd;

    assign pc_4    = pc + W_DATA'(4);
    assign jalra   = pc + W_DATA'(8);
    assign baddr   = {imm, 2'b00} + pc_4;
    assign jtarget = {pc_4[W_DATA-1:W_JADDR+2], jaddr, 2'b00};

    // eret wins over irq so the handler always gets one instruction back
    assign irq_take = irq && ie && !stall && !c_eret;
    assign ras_upd  = !stall && !irq_take;

    // Next-PC priority mux
    always_comb begin
        next_pc = pc_4;
        if (c_eret)             next_pc = epc;
        else if (c_ret)         next_pc = ras_top;
        else if (c_b && br_cond) next_pc = baddr;
        else if (c_j)           next_pc = (c_jjr == MUX_JRA) ? jra : jtarget;
    end

    // PC, exception return address and interrupt enable
    always_ff @(posedge clk) begin
        if (rst) begin
            pc  <= RESET_VECTOR;
            epc <= '0;
            ie  <= 1'b1;
        end else if (!stall) begin
            if (irq_take) begin
                pc  <= IRQ_VECTOR;
                epc <= next_pc;
                ie  <= 1'b0;
            end else begin
                pc <= next_pc;
                if (c_eret) ie <= 1'b1;
            end
        end
    end

    ras_stack #(
        .W     (W_DATA),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (ras_upd && c_call),
        .pop   (ras_upd && c_ret),
        .wdata (jalra),
        .top   (ras_top),
        .empty (ras_empty),
        .full  (ras_full),
        .uflow (ras_uflow)
    );

    assign imem_addr = pc;
endmodule
